wb_mailbox_slave: RTL and testbench

//  Wishbone B4 classic responder that sits on one slave port of the IO interconnect.

---
 rtl/wb_mailbox_slave.sv | 160 ++++++++++++++++
 tb/tb_wb_mailbox_slave.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mailbox_slave.sv
// Wishbone B4 classic mailbox slave: TX FIFO (bus->local), RX FIFO (local->bus).
// Optional irq_o output is built when WB_MBOX_IRQ_EN is defined.
module wb_mailbox_slave #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o,
  output logic [31:0] tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  input  logic [31:0] rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o
`ifdef WB_MBOX_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [CW-1:0]         cnt_t;

  logic [31:0] tx_mem [DEPTH];
  logic [31:0] rx_mem [DEPTH];
  ptr_t tx_rd, tx_wr, rx_rd, rx_wr;
  cnt_t tx_cnt, rx_cnt;

  logic tx_empty, tx_full, rx_empty, rx_full;
  logic req, bad, ok;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic ctrl_wr, tx_flush, rx_flush;
  logic irq_en;
  logic [31:0] status, rdata;
  logic unused_ok;

  assign unused_ok = ^{wb_cti_i, wb_bte_i, wb_adr_i[31:4], wb_adr_i[1:0]};

  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == cnt_t'(DEPTH));
  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == cnt_t'(DEPTH));

  assign status = {8'h00, 8'(rx_cnt), 8'(tx_cnt), 4'h0,
                   rx_full, rx_empty, tx_full, tx_empty};

  assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;

  always_comb begin
    bad   = 1'b0;
    rdata = 32'h0;
    unique case (wb_adr_i[3:2])
      2'd0: begin
        bad   = wb_we_i ? (tx_full || wb_sel_i != 4'hF) : rx_empty;
        rdata = rx_mem[rx_rd];
      end
      2'd1: begin
        bad   = wb_we_i;
        rdata = status;
      end
      2'd2: rdata = {29'd0, irq_en, 2'b00};
      default: bad = 1'b1;
    endcase
  end

  assign ok       = req & ~bad;
  assign tx_push  = ok & wb_we_i & (wb_adr_i[3:2] == 2'd0);
  assign rx_pop   = ok & ~wb_we_i & (wb_adr_i[3:2] == 2'd0);
  assign ctrl_wr  = ok & wb_we_i & (wb_adr_i[3:2] == 2'd2) & (|wb_sel_i);
  assign tx_flush = ctrl_wr & wb_dat_i[0];
  assign rx_flush = ctrl_wr & wb_dat_i[1];

  assign tx_valid_o = ~tx_empty;
  assign tx_data_o  = tx_mem[tx_rd];
  assign tx_pop     = tx_valid_o & tx_ready_i & ~tx_flush;

  // a bus pop frees the slot, so a full RX FIFO still takes a push that cycle
  assign rx_ready_o = ~rx_full | rx_pop;
  assign rx_push    = rx_valid_i & rx_ready_o & ~rx_flush;

  assign wb_rty_o = 1'b0;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= 32'h0;
    end else begin
      wb_ack_o <= ok;
      wb_err_o <= req & bad;
      wb_dat_o <= (ok & ~wb_we_i) ? rdata : 32'h0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      tx_rd  <= '0;
      tx_wr  <= '0;
      tx_cnt <= '0;
    end else if (tx_flush) begin
      tx_rd  <= '0;
      tx_wr  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      tx_cnt <= tx_cnt + cnt_t'(tx_push) - cnt_t'(tx_pop);
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      rx_rd  <= '0;
      rx_wr  <= '0;
      rx_cnt <= '0;
    end else if (rx_flush) begin
      rx_rd  <= '0;
      rx_wr  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
      rx_cnt <= rx_cnt + cnt_t'(rx_push) - cnt_t'(rx_pop);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (tx_push) tx_mem[tx_wr] <= wb_dat_i;
    if (rx_push) rx_mem[rx_wr] <= rx_data_i;
  end

`ifdef WB_MBOX_IRQ_EN
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      irq_en <= 1'b0;
      irq_o  <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en <= wb_dat_i[2];
      irq_o <= irq_en & (~rx_empty | tx_empty);
    end
  end
`else
  assign irq_en = 1'b0;
`endif

endmodule

// File: tb/tb_wb_mailbox_slave.sv
// Directed bench for wb_mailbox_slave: vector table plus FIFO corner sequences.
// Build with WB_MBOX_IRQ_EN defined to also exercise irq_o.
module tb_wb_mailbox_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] wdat = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic [31:0] rdat;
  logic        ack, err, rty;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [31:0] rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
`ifdef WB_MBOX_IRQ_EN
  logic        irq;
  localparam logic [31:0] CTRL_RB = 32'h4;
`else
  localparam logic [31:0] CTRL_RB = 32'h0;
`endif

  int total = 0;
  int bad = 0;

  wb_mailbox_slave #(.DEPTH_LOG2(3)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_cti_i(3'b000), .wb_bte_i(2'b00),
    .wb_dat_o(rdat), .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready)
`ifdef WB_MBOX_IRQ_EN
    , .irq_o(irq)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        exp_err;
    logic [31:0] exp_dat;
    logic        chk_dat;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic bus_p(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic push, input logic [31:0] pd,
                       output logic o_ack, output logic o_err, output logic [31:0] o_dat);
    int n;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    rx_valid = push; rx_data = pd;
    for (n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      rx_valid = 1'b0;
      if (ack | err) break;
    end
    o_ack = ack; o_err = err; o_dat = rdat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk("latency", 32'(n), 32'd0);
    @(posedge clk); #1;
    chk("term_1cyc", {30'd0, ack, err}, 32'd0);
  endtask

  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic o_ack, output logic o_err,
                     output logic [31:0] o_dat);
    bus_p(w, a, d, s, 1'b0, 32'h0, o_ack, o_err, o_dat);
  endtask

  task automatic rx_push(input logic [31:0] d);
    rx_data = d; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  logic        a, e;
  logic [31:0] d;

  initial begin
    vt[0]  = '{1'b0, 32'h4,         32'h0,         4'hF, 1'b0, 32'h0000_0005, 1'b1};
    vt[1]  = '{1'b1, 32'h0,         32'hA5A5_0001, 4'hF, 1'b0, 32'h0,         1'b0};
    vt[2]  = '{1'b0, 32'h4,         32'h0,         4'hF, 1'b0, 32'h0000_0104, 1'b1};
    vt[3]  = '{1'b1, 32'h0,         32'h1234_5678, 4'h3, 1'b1, 32'h0,         1'b0};
    vt[4]  = '{1'b1, 32'h4,         32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0,         1'b0};
    vt[5]  = '{1'b0, 32'hC,         32'h0,         4'hF, 1'b1, 32'h0,         1'b1};
    vt[6]  = '{1'b1, 32'hC,         32'h1,         4'hF, 1'b1, 32'h0,         1'b0};
    vt[7]  = '{1'b0, 32'h0,         32'h0,         4'hF, 1'b1, 32'h0,         1'b1};
    vt[8]  = '{1'b1, 32'h8,         32'h4,         4'hF, 1'b0, 32'h0,         1'b0};
    vt[9]  = '{1'b0, 32'h8,         32'h0,         4'hF, 1'b0, CTRL_RB,       1'b1};
    vt[10] = '{1'b1, 32'h8,         32'h1,         4'h0, 1'b0, 32'h0,         1'b0};
    vt[11] = '{1'b0, 32'h4,         32'h0,         4'hF, 1'b0, 32'h0000_0104, 1'b1};
    vt[12] = '{1'b1, 32'h8,         32'h1,         4'h1, 1'b0, 32'h0,         1'b0};
    vt[13] = '{1'b0, 32'h1000_0004, 32'h0,         4'hF, 1'b0, 32'h0000_0005, 1'b1};
    vt[14] = '{1'b0, 32'h8,         32'h0,         4'hF, 1'b0, 32'h0,         1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_dat", rdat, 32'd0);
    chk("rst_txv", {31'd0, tx_valid}, 32'd0);
    chk("rst_rxr", {31'd0, rx_ready}, 32'd1);
    chk("rty", {31'd0, rty}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      bus(vt[i].we, vt[i].adr, vt[i].dat, vt[i].sel, a, e, d);
      chk($sformatf("vec%0d_term", i), {30'd0, a, e}, {30'd0, ~vt[i].exp_err, vt[i].exp_err});
      if (vt[i].chk_dat) chk($sformatf("vec%0d_dat", i), d, vt[i].exp_dat);
      if (i == 1) begin
        chk("tx_valid_1", {31'd0, tx_valid}, 32'd1);
        chk("tx_data_1", tx_data, 32'hA5A5_0001);
      end
    end

    // cancelled requests: stb or cyc low never terminates
    cyc = 1'b1; stb = 1'b0; we = 1'b1; adr = 32'h0; wdat = 32'hDEAD; sel = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    chk("cancel_stb", {30'd0, ack, err}, 32'd0);
    cyc = 1'b0; stb = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("cancel_cyc", {30'd0, ack, err}, 32'd0);
    stb = 1'b0; we = 1'b0;
    bus(1'b0, 32'h4, 32'h0, 4'hF, a, e, d);
    chk("cancel_stat", d, 32'h0000_0005);

    // TX full
    for (int i = 0; i < 8; i++) begin
      bus(1'b1, 32'h0, 32'hA5A5_0001 + 32'(i), 4'hF, a, e, d);
      chk("tx_fill_ack", {31'd0, a}, 32'd1);
    end
    bus(1'b0, 32'h4, 32'h0, 4'hF, a, e, d);
    chk("tx_full_stat", d, 32'h0000_0806);
    bus(1'b1, 32'h0, 32'hBAD0_0009, 4'hF, a, e, d);
    chk("tx_ovf_err", {30'd0, a, e}, 32'd1);
    bus(1'b0, 32'h4, 32'h0, 4'hF, a, e, d);
    chk("tx_ovf_stat", d, 32'h0000_0806);
    chk("tx_head", tx_data, 32'hA5A5_0001);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    chk("tx_pop_head", tx_data, 32'hA5A5_0002);
    bus(1'b0, 32'h4, 32'h0, 4'hF, a, e, d);
    chk("tx_pop_stat", d, 32'h0000_0704);
    bus(1'b1, 32'h8, 32'h1, 4'hF, a, e, d);
    chk("tx_flush_v", {31'd0, tx_valid}, 32'd0);

    // RX path
    rx_push(32'h11);
    rx_push(32'h22);
    bus(1'b0, 32'h0, 32'h0, 4'hF, a, e, d);
    chk("rx_rd1", d, 32'h11);
    bus(1'b0, 32'h0, 32'h0, 4'hF, a, e, d);
    chk("rx_rd2", d, 32'h22);
    bus(1'b0, 32'h0, 32'h0, 4'hF, a, e, d);
    chk("rx_rd3_err", {30'd0, a, e}, 32'd1);
    chk("rx_rd3_dat", d, 32'h0);

    // RX full with same-cycle push and pop
    for (int i = 0; i < 8; i++) rx_push(32'h100 + 32'(i));
    chk("rx_full_rdy", {31'd0, rx_ready}, 32'd0);
    bus(1'b0, 32'h4, 32'h0, 4'hF, a, e, d);
    chk("rx_full_stat", d, 32'h0008_0009);
    bus_p(1'b0, 32'h0, 32'h0, 4'hF, 1'b1, 32'h200, a, e, d);
    chk("rx_pp_dat", d, 32'h100);
    bus(1'b0, 32'h4, 32'h0, 4'hF, a, e, d);
    chk("rx_pp_stat", d, 32'h0008_0009);
    for (int i = 1; i < 9; i++) begin
      bus(1'b0, 32'h0, 32'h0, 4'hF, a, e, d);
      chk($sformatf("rx_order%0d", i), d, (i < 8) ? 32'h100 + 32'(i) : 32'h200);
    end
    bus(1'b0, 32'h4, 32'h0, 4'hF, a, e, d);
    chk("rx_drain_stat", d, 32'h0000_0005);

    // flush both FIFOs while the local side pushes
    bus(1'b1, 32'h0, 32'h1, 4'hF, a, e, d);
    bus(1'b1, 32'h0, 32'h2, 4'hF, a, e, d);
    rx_push(32'h55);
    bus(1'b0, 32'h4, 32'h0, 4'hF, a, e, d);
    chk("pre_flush_stat", d, 32'h0001_0200);
    bus_p(1'b1, 32'h8, 32'h3, 4'hF, 1'b1, 32'h333, a, e, d);
    chk("flush_ack", {31'd0, a}, 32'd1);
    bus(1'b0, 32'h4, 32'h0, 4'hF, a, e, d);
    chk("flush_stat", d, 32'h0000_0005);

`ifdef WB_MBOX_IRQ_EN
    bus(1'b1, 32'h8, 32'h4, 4'hF, a, e, d);
    chk("irq_on", {31'd0, irq}, 32'd1);
    bus(1'b1, 32'h8, 32'h0, 4'hF, a, e, d);
`endif

    // reset mid-access with TX holding 3 words
    for (int i = 0; i < 3; i++) bus(1'b1, 32'h0, 32'h70 + 32'(i), 4'hF, a, e, d);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h4;
    @(posedge clk); #1;
    chk("mid_ack_pre", {31'd0, ack}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_ack_rst", {31'd0, ack}, 32'd0);
    chk("mid_txv_rst", {31'd0, tx_valid}, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus(1'b0, 32'h4, 32'h0, 4'hF, a, e, d);
    chk("mid_stat", d, 32'h0000_0005);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
